// File: rtl/aes_bus_pkg.sv
`default_nettype none
// ============================================================================
// Module   : aes_bus_pkg
// Purpose  : Shared types and constants for the AES128 bus-side controller:
//            FSM state encoding, bus register map and status bit positions.
// Revision : 1.0 - initial multi-word bus controller
// ============================================================================
package aes_bus_pkg;

    // Controller states, explicitly encoded in 3 bits
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOADING = 3'd1,
        READY   = 3'd2,
        RUN     = 3'd3,
        DONE    = 3'd4
    } state_t;

    // Bus register map
    localparam int ADDR_MSG    = 0;
    localparam int ADDR_KEY    = 1;
    localparam int ADDR_CTRL   = 2;
    localparam int ADDR_RESULT = 3;

    // Status word layout: {err, done, busy, key_full, msg_full}
    localparam int STAT_W        = 5;
    localparam int STAT_MSG_FULL = 0;
    localparam int STAT_KEY_FULL = 1;
    localparam int STAT_BUSY     = 2;
    localparam int STAT_DONE     = 3;
    localparam int STAT_ERR      = 4;

    // Where the input-collection phase sits, given the post-access fill levels
    function automatic state_t fill_state(input logic msg_full,
                                          input logic key_full,
                                          input logic any_words);
        if (msg_full && key_full) begin
            return READY;
        end else if (any_words) begin
            return LOADING;
        end
        return IDLE;
    endfunction

endpackage
`default_nettype wire

// File: rtl/aes_bus_ctrl_counter.sv
`default_nettype none
// ============================================================================
// Module   : aes_word_counter
// Purpose  : Saturating word counter. Counts up on i_inc, stops at
//            MAX_COUNT, clears synchronously on i_clr (clear has priority).
// Revision : 1.0 - initial multi-word bus controller
// ============================================================================
module aes_word_counter #(
    parameter int MAX_COUNT = 4,
    parameter int CNT_W     = $clog2(MAX_COUNT + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_inc,
    input  logic             i_clr,
    output logic [CNT_W-1:0] o_cnt,
    output logic             o_full
);

    logic [CNT_W-1:0] r_cnt;
    logic             w_full;

    assign w_full = (r_cnt == CNT_W'(MAX_COUNT));

    // Count words; saturate at MAX_COUNT instead of wrapping
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_inc && !w_full) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_cnt  = r_cnt;
    assign o_full = w_full;

endmodule
`default_nettype wire

// File: rtl/aes_bus_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : aes_bus_ctrl
// Purpose  : Bus-side control FSM for the AES128 core. Collects multi-word
//            message/key transfers, starts the core, waits for completion
//            and sequences the word-by-word result read-out. Drives strobes
//            only; the shift registers live in the datapath.
// Revision : 1.0 - initial multi-word bus controller
// ============================================================================
module aes_bus_ctrl
    import aes_bus_pkg::*;
#(
    parameter int BUS_W   = 32,
    parameter int BLOCK_W = 128,
    parameter int ADDR_W  = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              CS,
    input  logic              RW,
    input  logic [ADDR_W-1:0] adress,
    input  logic              core_done,
    output logic              shift_in_message,
    output logic              shift_in_key,
    output logic              load,
    output logic              shift_out,
    output logic [4:0]        status
);

    localparam int NUM_WORDS = BLOCK_W / BUS_W;
    localparam int CNT_W     = $clog2(NUM_WORDS + 1);

    // Registered state and outputs
    state_t r_state;
    logic   r_cs_q;
    logic   r_shift_in_message;
    logic   r_shift_in_key;
    logic   r_load;
    logic   r_shift_out;
    logic   r_err;
    logic   r_busy;
    logic   r_done;

    // Counter interface
    logic [CNT_W-1:0] w_msg_cnt;
    logic [CNT_W-1:0] w_key_cnt;
    logic [CNT_W-1:0] w_out_cnt;
    logic             w_msg_full;
    logic             w_key_full;
    logic             w_out_full;

    // Access decode
    logic w_access;
    logic w_wr;
    logic w_rd;
    logic w_sel_msg;
    logic w_sel_key;
    logic w_sel_ctrl;
    logic w_sel_res;

    // Next-cycle decisions
    state_t           w_nxt_state;
    logic             w_msg_inc;
    logic             w_key_inc;
    logic             w_out_inc;
    logic             w_load;
    logic             w_clr_all;
    logic             w_err_set;
    logic             w_err_clr;
    logic             w_abort;
    logic [CNT_W-1:0] w_msg_post;
    logic [CNT_W-1:0] w_key_post;

    // One access per rising edge of CS, however long it stays high
    assign w_access   = CS & ~r_cs_q;
    assign w_wr       = w_access &  RW;
    assign w_rd       = w_access & ~RW;
    assign w_sel_msg  = (adress == ADDR_W'(ADDR_MSG));
    assign w_sel_key  = (adress == ADDR_W'(ADDR_KEY));
    assign w_sel_ctrl = (adress == ADDR_W'(ADDR_CTRL));
    assign w_sel_res  = (adress == ADDR_W'(ADDR_RESULT));

    aes_word_counter #(.MAX_COUNT(NUM_WORDS), .CNT_W(CNT_W)) u_msg_cnt (
        .clk    (clk),
        .rst    (reset),
        .i_inc  (w_msg_inc),
        .i_clr  (w_clr_all),
        .o_cnt  (w_msg_cnt),
        .o_full (w_msg_full)
    );

    aes_word_counter #(.MAX_COUNT(NUM_WORDS), .CNT_W(CNT_W)) u_key_cnt (
        .clk    (clk),
        .rst    (reset),
        .i_inc  (w_key_inc),
        .i_clr  (w_clr_all),
        .o_cnt  (w_key_cnt),
        .o_full (w_key_full)
    );

    aes_word_counter #(.MAX_COUNT(NUM_WORDS), .CNT_W(CNT_W)) u_out_cnt (
        .clk    (clk),
        .rst    (reset),
        .i_inc  (w_out_inc),
        .i_clr  (w_clr_all),
        .o_cnt  (w_out_cnt),
        .o_full (w_out_full)
    );

    // Decode the accepted access against the current state
    always_comb begin
        w_nxt_state = r_state;
        w_msg_inc   = 1'b0;
        w_key_inc   = 1'b0;
        w_out_inc   = 1'b0;
        w_load      = 1'b0;
        w_clr_all   = 1'b0;
        w_err_set   = 1'b0;
        w_err_clr   = 1'b0;
        w_abort     = 1'b0;
        w_msg_post  = w_msg_cnt;
        w_key_post  = w_key_cnt;

        if (w_wr && w_sel_res) begin
            // Soft abort: valid from every state, silently resets the flow
            w_abort     = 1'b1;
            w_clr_all   = 1'b1;
            w_nxt_state = IDLE;
        end else begin
            if (w_rd && w_sel_ctrl) begin
                w_err_clr = 1'b1;
            end
            if (w_rd && w_sel_res && (r_state != DONE)) begin
                w_err_set = 1'b1;
            end

            case (r_state)
                IDLE, LOADING, READY: begin
                    if (w_wr && w_sel_msg) begin
                        if (w_msg_full) w_err_set = 1'b1;
                        else            w_msg_inc = 1'b1;
                    end
                    if (w_wr && w_sel_key) begin
                        if (w_key_full) w_err_set = 1'b1;
                        else            w_key_inc = 1'b1;
                    end
                    if (w_wr && w_sel_ctrl) begin
                        if (r_state == READY) w_load    = 1'b1;
                        else                  w_err_set = 1'b1;
                    end
                    w_msg_post = w_msg_cnt + CNT_W'(w_msg_inc);
                    w_key_post = w_key_cnt + CNT_W'(w_key_inc);
                    if (w_load) begin
                        w_nxt_state = RUN;
                    end else begin
                        w_nxt_state = fill_state(w_msg_post == CNT_W'(NUM_WORDS),
                                                 w_key_post == CNT_W'(NUM_WORDS),
                                                 (w_msg_post != '0) || (w_key_post != '0));
                    end
                end
                RUN: begin
                    // Inputs are frozen while the core is working
                    if (w_wr) begin
                        w_err_set = 1'b1;
                    end
                    if (core_done) begin
                        w_nxt_state = DONE;
                    end
                end
                DONE: begin
                    if (w_wr) begin
                        w_err_set = 1'b1;
                    end
                    if (w_rd && w_sel_res) begin
                        w_out_inc = 1'b1;
                        // Last word drained (saturation is a defensive catch)
                        if ((w_out_cnt == CNT_W'(NUM_WORDS - 1)) || w_out_full) begin
                            w_clr_all   = 1'b1;
                            w_nxt_state = IDLE;
                        end
                    end
                end
                default: begin
                    w_clr_all   = 1'b1;
                    w_nxt_state = IDLE;
                end
            endcase
        end
    end

    // State, 1-cycle strobes and sticky flags, all registered
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state            <= IDLE;
            r_cs_q             <= 1'b0;
            r_shift_in_message <= 1'b0;
            r_shift_in_key     <= 1'b0;
            r_load             <= 1'b0;
            r_shift_out        <= 1'b0;
            r_err              <= 1'b0;
            r_busy             <= 1'b0;
            r_done             <= 1'b0;
        end else begin
            r_cs_q             <= CS;
            r_state            <= w_nxt_state;
            r_shift_in_message <= w_msg_inc;
            r_shift_in_key     <= w_key_inc;
            r_load             <= w_load;
            r_shift_out        <= w_out_inc;
            r_busy             <= (w_nxt_state == RUN);
            r_done             <= (w_nxt_state == DONE);
            // A new error on the same edge as a clear keeps err set
            if (w_err_set) begin
                r_err <= 1'b1;
            end else if (w_err_clr || w_abort) begin
                r_err <= 1'b0;
            end
        end
    end

    assign shift_in_message        = r_shift_in_message;
    assign shift_in_key            = r_shift_in_key;
    assign load                    = r_load;
    assign shift_out               = r_shift_out;
    assign status[STAT_ERR]        = r_err;
    assign status[STAT_DONE]       = r_done;
    assign status[STAT_BUSY]       = r_busy;
    assign status[STAT_KEY_FULL]   = w_key_full;
    assign status[STAT_MSG_FULL]   = w_msg_full;

endmodule
`default_nettype wire

// File: tb/tb_aes_bus_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_aes_bus_ctrl
// Purpose  : Scoreboard bench for aes_bus_ctrl. Stimulus pushes the expected
//            strobe and status for each accepted edge; a negedge monitor pops
//            and compares whatever the controller presents.
// Revision : 1.0 - initial multi-word bus controller
// ============================================================================
module tb_aes_bus_ctrl;

    localparam int K_MSG  = 0;
    localparam int K_KEY  = 1;
    localparam int K_LOAD = 2;
    localparam int K_OUT  = 3;
    localparam int K_NONE = -1;

    logic       clk;
    logic       reset;
    logic       CS;
    logic       RW;
    logic [1:0] adress;
    logic       core_done;
    logic       shift_in_message;
    logic       shift_in_key;
    logic       load;
    logic       shift_out;
    logic [4:0] status;

    typedef struct {
        int kind;
        int cyc;
    } strobe_t;

    typedef struct {
        int         cyc;
        logic [4:0] val;
    } stat_t;

    strobe_t exp_strobe[$];
    stat_t   exp_stat[$];
    int      cyc;
    int      n_cmp;
    int      n_bad;

    aes_bus_ctrl #(.BUS_W(32), .BLOCK_W(128), .ADDR_W(2)) dut (
        .clk              (clk),
        .reset            (reset),
        .CS               (CS),
        .RW               (RW),
        .adress           (adress),
        .core_done        (core_done),
        .shift_in_message (shift_in_message),
        .shift_in_key     (shift_in_key),
        .load             (load),
        .shift_out        (shift_out),
        .status           (status)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: compare every presented strobe and every due status sample
    always @(negedge clk) begin
        int nhi;
        int kind;
        nhi  = int'(shift_in_message) + int'(shift_in_key) + int'(load) + int'(shift_out);
        kind = shift_in_message ? K_MSG : shift_in_key ? K_KEY : load ? K_LOAD : K_OUT;
        if (nhi > 1) begin
            n_cmp++;
            n_bad++;
            $display("FAIL onehot cyc=%0d got %0d strobes high, want at most 1", cyc, nhi);
        end
        if (nhi != 0) begin
            n_cmp++;
            if (exp_strobe.size() == 0) begin
                n_bad++;
                $display("FAIL strobe cyc=%0d got kind %0d, want none", cyc, kind);
            end else begin
                strobe_t e;
                e = exp_strobe.pop_front();
                if (e.kind != kind || e.cyc != cyc) begin
                    n_bad++;
                    $display("FAIL strobe got kind %0d at cyc %0d, want kind %0d at cyc %0d",
                             kind, cyc, e.kind, e.cyc);
                end
            end
        end
        if (exp_strobe.size() != 0 && exp_strobe[0].cyc < cyc) begin
            strobe_t m;
            m = exp_strobe.pop_front();
            n_cmp++;
            n_bad++;
            $display("FAIL strobe_missing got none, want kind %0d at cyc %0d", m.kind, m.cyc);
        end
        while (exp_stat.size() != 0 && exp_stat[0].cyc <= cyc) begin
            stat_t s;
            s = exp_stat.pop_front();
            n_cmp++;
            if (s.cyc != cyc || status !== s.val) begin
                n_bad++;
                $display("FAIL status cyc=%0d got %b, want %b (due cyc %0d)", cyc, status, s.val, s.cyc);
            end
        end
    end

    // One bus access; CS stays high for 'hold' cycles
    task automatic access(input logic rw, input logic [1:0] adr, input int kind,
                          input logic [4:0] st, input int hold);
        @(negedge clk);
        CS     = 1'b1;
        RW     = rw;
        adress = adr;
        @(posedge clk);
        #1;
        if (kind != K_NONE) exp_strobe.push_back('{kind, cyc});
        exp_stat.push_back('{cyc, st});
        repeat (hold - 1) @(posedge clk);
        @(negedge clk);
        CS = 1'b0;
    endtask

    task automatic wr(input logic [1:0] adr, input int kind, input logic [4:0] st);
        access(1'b1, adr, kind, st, 1);
    endtask

    task automatic rd(input logic [1:0] adr, input int kind, input logic [4:0] st);
        access(1'b0, adr, kind, st, 1);
    endtask

    task automatic pulse_done(input logic [4:0] st);
        @(negedge clk);
        core_done = 1'b1;
        @(posedge clk);
        #1;
        exp_stat.push_back('{cyc, st});
        @(negedge clk);
        core_done = 1'b0;
    endtask

    task automatic fill_both();
        wr(2'd0, K_MSG, 5'b00000);
        wr(2'd0, K_MSG, 5'b00000);
        wr(2'd0, K_MSG, 5'b00000);
        wr(2'd0, K_MSG, 5'b00001);
        wr(2'd1, K_KEY, 5'b00001);
        wr(2'd1, K_KEY, 5'b00001);
        wr(2'd1, K_KEY, 5'b00001);
        wr(2'd1, K_KEY, 5'b00011);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        cyc       = 0;
        n_cmp     = 0;
        n_bad     = 0;
        reset     = 1'b1;
        CS        = 1'b0;
        RW        = 1'b0;
        adress    = 2'd0;
        core_done = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if (status !== 5'b0) begin
            n_bad++;
            $display("FAIL reset_status got %b, want 00000", status);
        end
        n_cmp++;
        if ({shift_in_message, shift_in_key, load, shift_out} !== 4'b0) begin
            n_bad++;
            $display("FAIL reset_strobes got %b, want 0000",
                     {shift_in_message, shift_in_key, load, shift_out});
        end
        @(negedge clk);
        reset = 1'b0;

        // Message then key fill, start, completion, full read-out
        fill_both();
        wr(2'd2, K_LOAD, 5'b00111);
        repeat (2) @(posedge clk);
        pulse_done(5'b01011);
        rd(2'd3, K_OUT, 5'b01011);
        rd(2'd3, K_OUT, 5'b01011);
        rd(2'd3, K_OUT, 5'b01011);
        rd(2'd3, K_OUT, 5'b00000);

        // Overfill, premature start, error clear, abort, stray result read
        wr(2'd0, K_MSG, 5'b00000);
        wr(2'd0, K_MSG, 5'b00000);
        wr(2'd0, K_MSG, 5'b00000);
        wr(2'd0, K_MSG, 5'b00001);
        wr(2'd0, K_NONE, 5'b10001);
        wr(2'd1, K_KEY, 5'b10001);
        wr(2'd1, K_KEY, 5'b10001);
        wr(2'd2, K_NONE, 5'b10001);
        rd(2'd2, K_NONE, 5'b00001);
        wr(2'd3, K_NONE, 5'b00000);
        rd(2'd3, K_NONE, 5'b10000);
        rd(2'd2, K_NONE, 5'b00000);

        // CS held high produces a single access
        access(1'b1, 2'd0, K_MSG, 5'b00000, 10);
        wr(2'd3, K_NONE, 5'b00000);

        // Async reset while running with bad reads pending
        fill_both();
        wr(2'd2, K_LOAD, 5'b00111);
        rd(2'd3, K_NONE, 5'b10111);
        rd(2'd3, K_NONE, 5'b10111);
        @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        n_cmp++;
        if (status !== 5'b0) begin
            n_bad++;
            $display("FAIL async_reset_status got %b, want 00000", status);
        end
        n_cmp++;
        if ({shift_in_message, shift_in_key, load, shift_out} !== 4'b0) begin
            n_bad++;
            $display("FAIL async_reset_strobes got %b, want 0000",
                     {shift_in_message, shift_in_key, load, shift_out});
        end
        @(negedge clk);
        reset = 1'b0;
        pulse_done(5'b00000);
        rd(2'd2, K_NONE, 5'b00000);

        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        n_cmp++;
        if (exp_strobe.size() != 0 || exp_stat.size() != 0) begin
            n_bad++;
            $display("FAIL leftover got %0d strobes %0d status pending, want 0 0",
                     exp_strobe.size(), exp_stat.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
